// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t MIPS_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam word_t MIPS_RESET_PC  = 32'h0000_0000;
  localparam word_t ALIGN_MASK     = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic word_t word_align(input word_t addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: enable-gated load of a delivered instruction,
// otherwise a bubble (NOP, invalid, PC+4 kept).
module if_id_reg
  import mips_pkg::*;
#(
  parameter word_t NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  load,
  input  word_t instr,
  input  word_t pc_plus4,
  output word_t instr_d,
  output word_t pc_plus4_d,
  output logic  valid_d
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (en) begin
      if (load) begin
        instr_d    <= instr;
        pc_plus4_d <= pc_plus4;
        valid_d    <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PC_F, fetches over a one-outstanding variable-latency port.
// Optional FETCH_PERF_CNT_EN adds Bubble_Cnt / Redirect_Cnt outputs.
//
// state | meaning
// ISSUE | request PC_F, waiting for grant
// WAIT  | request granted, waiting for response (Drop=1 discards it)
// HOLD  | response captured in hold_instr while Stall_F is high
module fetch_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC  = MIPS_RESET_PC,
  parameter word_t NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall_F,
  input  logic              Stall_D,
  input  logic              PC_Src_D,
  input  logic [WORD_W-1:0] PC_Branch_D,
  output logic              IMem_Req,
  output logic [WORD_W-1:0] IMem_Addr,
  input  logic              IMem_Gnt,
  input  logic              IMem_Rvalid,
  input  logic [WORD_W-1:0] IMem_Rdata,
  output logic [WORD_W-1:0] Instr_D,
  output logic [WORD_W-1:0] PC_Plus4_D,
  output logic              Valid_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       Bubble_Cnt,
  output logic [31:0]       Redirect_Cnt
`endif
);

  fetch_state_t state, state_nxt;
  word_t        pc_f, pc_nxt, pc_plus4_f;
  word_t        hold_instr, hold_nxt, deliver_instr;
  logic         drop, drop_nxt;
  logic         redirect, deliver;

  assign pc_plus4_f = pc_f + 32'd4;
  assign redirect   = PC_Src_D && !Stall_D;
  assign IMem_Addr  = pc_f;

  // A reset during WAIT leaves a response in flight; Drop survives reset until it lands.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ISSUE;
      pc_f       <= RESET_PC;
      drop       <= (state == WAIT) || (drop && !IMem_Rvalid);
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc_f       <= pc_nxt;
      drop       <= drop_nxt;
      hold_instr <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    hold_nxt  = hold_instr;
    pc_nxt    = pc_f;
    case (state)
      ISSUE: begin
        if (drop && IMem_Rvalid) drop_nxt = 1'b0;
        if (IMem_Gnt) begin
          state_nxt = WAIT;
          if (redirect) drop_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (IMem_Rvalid) begin
          state_nxt = ISSUE;
          if (drop) begin
            drop_nxt = 1'b0;
          end else if (!redirect && Stall_F) begin
            state_nxt = HOLD;
            hold_nxt  = IMem_Rdata;
          end
        end else if (redirect) begin
          drop_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || !Stall_F) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
    if (redirect)     pc_nxt = word_align(PC_Branch_D);
    else if (deliver) pc_nxt = pc_plus4_f;
  end

  always_comb begin
    IMem_Req      = 1'b0;
    deliver       = 1'b0;
    deliver_instr = IMem_Rdata;
    case (state)
      ISSUE: IMem_Req = !Rst;
      WAIT:  deliver  = IMem_Rvalid && !drop && !redirect && !Stall_F;
      HOLD: begin
        deliver       = !redirect && !Stall_F;
        deliver_instr = hold_instr;
      end
      default: ;
    endcase
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (Clk),
    .rst        (Rst),
    .en         (!Stall_D),
    .load       (deliver),
    .instr      (deliver_instr),
    .pc_plus4   (pc_plus4_f),
    .instr_d    (Instr_D),
    .pc_plus4_d (PC_Plus4_D),
    .valid_d    (Valid_D)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Bubble_Cnt   <= '0;
      Redirect_Cnt <= '0;
    end else begin
      if (!Stall_D && !deliver) Bubble_Cnt <= Bubble_Cnt + 32'd1;
      if (redirect) Redirect_Cnt <= Redirect_Cnt + 32'd1;
    end
  end
`endif

endmodule
